// File: rtl/keypad_scan_decoder.sv
// Column-strobed 4x4 matrix keypad scanner with whole-scan debounce and one hex code per press.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of key_valid while a single key stays held.
module keypad_scan_decoder #(
    parameter int SCAN_DIV_BITS  = 17,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 96
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                 REP_W    = $clog2(REPEAT_SCANS + 1);
    localparam logic [3:0]         DB_CNT   = 4'(DEBOUNCE_SCANS);
    localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT_SCANS - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        REL_DB
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_ONE,
        SCAN_MULTI
    } scan_class_t;

    logic [3:0]               row_meta_q,  row_meta_d;
    logic [3:0]               row_sync_q,  row_sync_d;
    logic [SCAN_DIV_BITS-1:0] div_q,       div_d;
    logic [1:0]               col_idx_q,   col_idx_d;
    logic [3:0]               col_out_q,   col_out_d;
    logic [15:0]              image_q,     image_d;
    logic                     scan_done_q, scan_done_d;
    state_t                   state_q,     state_d;
    logic [3:0]               cand_q,      cand_d;
    logic [3:0]               cnt_q,       cnt_d;
    logic [REP_W-1:0]         rep_q,       rep_d;
    logic [3:0]               key_code_q,  key_code_d;
    logic                     key_valid_q, key_valid_d;
    logic                     key_held_q,  key_held_d;

    logic                     dwell_end;
    logic [4:0]               key_count;
    logic [3:0]               scan_code;
    scan_class_t              scan_class;
    logic                     accept_key;
    logic                     drop_key;

    // Physical keypad position (row r, column k) to the legend printed on the key.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Image bit col*4+row is set when that key was seen pressed during its column's dwell.
    always_comb begin
        dwell_end   = (div_q == '1);
        row_meta_d  = row_in;
        row_sync_d  = row_meta_q;
        div_d       = div_q + SCAN_DIV_BITS'(1);
        col_idx_d   = col_idx_q;
        col_out_d   = col_out_q;
        image_d     = image_q;
        scan_done_d = 1'b0;
        if (dwell_end) begin
            image_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
            col_idx_d   = col_idx_q + 2'd1;
            col_out_d   = {col_out_q[2:0], col_out_q[3]};
            scan_done_d = (col_idx_q == 2'd3);
        end
    end

    always_comb begin
        key_count = '0;
        scan_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (image_q[i]) begin
                key_count = key_count + 5'd1;
                scan_code = key_map(i[1:0], i[3:2]);
            end
        end
        if (key_count == 5'd0) begin
            scan_class = SCAN_NONE;
        end else if (key_count == 5'd1) begin
            scan_class = SCAN_ONE;
        end else begin
            scan_class = SCAN_MULTI;
        end
    end

    // Press/release debounce; only advances on the cycle after a full scan completes.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept_key  = 1'b0;
        drop_key    = 1'b0;
        if (scan_done_q) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_class == SCAN_ONE) begin
                        cand_d     = scan_code;
                        cnt_d      = 4'd1;
                        state_d    = PRESS_DB;
                        accept_key = (DEBOUNCE_SCANS == 1);
                    end
                end
                PRESS_DB: begin
                    if (scan_class == SCAN_ONE && scan_code == cand_q) begin
                        cnt_d      = cnt_q + 4'd1;
                        accept_key = (cnt_d == DB_CNT);
                    end else if (scan_class == SCAN_ONE) begin
                        cand_d = scan_code;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (scan_class == SCAN_NONE) begin
                        cnt_d    = 4'd1;
                        rep_d    = '0;
                        state_d  = REL_DB;
                        drop_key = (DEBOUNCE_SCANS == 1);
                    end else if (REPEAT_EN && scan_class == SCAN_ONE && scan_code == cand_q) begin
                        if (rep_q == REP_LAST) begin
                            rep_d       = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end else begin
                        rep_d = '0;
                    end
                end
                REL_DB: begin
                    if (scan_class == SCAN_NONE) begin
                        cnt_d    = cnt_q + 4'd1;
                        drop_key = (cnt_d == DB_CNT);
                    end else begin
                        cnt_d   = '0;
                        rep_d   = '0;
                        state_d = PRESSED;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (accept_key) begin
                key_code_d  = cand_d;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                cnt_d       = '0;
                rep_d       = '0;
                state_d     = PRESSED;
            end
            if (drop_key) begin
                key_held_d = 1'b0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            image_q     <= '0;
            scan_done_q <= 1'b0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            image_q     <= image_d;
            scan_done_q <= scan_done_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a keypad model driven per scan, checked against a code-level debounce model.
// Build with KEYPAD_REPEAT_EN defined to exercise auto-repeat in both DUT and model.
module tb_keypad_scan_decoder;

    localparam int SCAN_DIV_BITS  = 3;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int REPEAT_SCANS   = 4;
    localparam int SCAN_CYCLES    = 4 << SCAN_DIV_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] key_mask = '0;
    int          checks = 0;
    int          errors = 0;
    int          pulse_seen = 0;
    int          pulse_expected = 0;
    int          code_change_bad = 0;
    logic [3:0]  prev_code = '0;

    bit          m_held;
    logic [3:0]  m_code;
    logic [3:0]  m_run_code;
    int          m_run_len;
    int          m_none_run;
    int          m_rep;
    bit          m_pulse;

    keypad_scan_decoder #(
        .SCAN_DIV_BITS  (SCAN_DIV_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_SCANS   (REPEAT_SCANS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Where each legend sits on the Pmod KYPD face.
    function automatic logic [1:0] rowOf(input logic [3:0] code);
        case (code)
            4'h1, 4'h2, 4'h3, 4'hA: return 2'd0;
            4'h4, 4'h5, 4'h6, 4'hB: return 2'd1;
            4'h7, 4'h8, 4'h9, 4'hC: return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] colOf(input logic [3:0] code);
        case (code)
            4'h1, 4'h4, 4'h7, 4'h0: return 2'd0;
            4'h2, 4'h5, 4'h8, 4'hF: return 2'd1;
            4'h3, 4'h6, 4'h9, 4'hE: return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 16; c++) begin
            if (key_mask[c] && col_out[colOf(c[3:0])] == 1'b0) begin
                row_in[rowOf(c[3:0])] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] maskOf(input logic [3:0] code);
        logic [15:0] m;
        m = '0;
        m[code] = 1'b1;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        if (key_valid === 1'b1) pulse_seen++;
        if (!reset && key_code !== prev_code && key_valid !== 1'b1) code_change_bad++;
        prev_code = key_code;
    endtask

    task automatic modelReset();
        m_held     = 1'b0;
        m_code     = '0;
        m_run_code = '0;
        m_run_len  = 0;
        m_none_run = 0;
        m_rep      = 0;
        m_pulse    = 1'b0;
    endtask

    // One full scan seen by the keypad user: classify by number of keys down, then apply the press/release rules.
    task automatic modelScan(input logic [15:0] mask);
        int         n;
        logic [3:0] c;
        n = $countones(mask);
        c = '0;
        for (int i = 0; i < 16; i++) if (mask[i]) c = 4'(i);
        m_pulse = 1'b0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run_len > 0 && m_run_code == c) begin
                    m_run_len++;
                end else begin
                    m_run_code = c;
                    m_run_len  = 1;
                end
                if (m_run_len >= DEBOUNCE_SCANS) begin
                    m_held     = 1'b1;
                    m_code     = c;
                    m_pulse    = 1'b1;
                    m_run_len  = 0;
                    m_none_run = 0;
                    m_rep      = 0;
                end
            end else begin
                m_run_len = 0;
            end
        end else if (n == 0) begin
            m_none_run++;
            m_rep = 0;
            if (m_none_run >= DEBOUNCE_SCANS) begin
                m_held     = 1'b0;
                m_none_run = 0;
                m_run_len  = 0;
            end
        end else if (m_none_run > 0) begin
            m_none_run = 0;
            m_rep      = 0;
        end else if (n == 1 && c == m_code) begin
`ifdef KEYPAD_REPEAT_EN
            m_rep++;
            if (m_rep == REPEAT_SCANS) begin
                m_rep   = 0;
                m_pulse = 1'b1;
            end
`endif
        end else begin
            m_rep = 0;
        end
        if (m_pulse) pulse_expected++;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".valid"},  32'(key_valid), 32'(m_pulse));
        checkOutput({tag, ".code"},   32'(key_code),  32'(m_code));
        checkOutput({tag, ".held"},   32'(key_held),  32'(m_held));
        checkOutput({tag, ".pulses"}, 32'(pulse_seen), 32'(pulse_expected));
    endtask

    // Hold the given keys for one whole scan; the scan's verdict is visible at the last step.
    task automatic applyStimulus(input logic [15:0] mask, input string tag);
        key_mask = mask;
        repeat (SCAN_CYCLES) stepCycle();
        modelScan(mask);
        checkModel(tag);
    endtask

    task automatic doReset(input int cycles, input string tag);
        reset = 1'b1;
        stepCycle();
        checkOutput({tag, ".col_edge"},   32'(col_out),   32'h0000_000E);
        checkOutput({tag, ".valid_edge"}, 32'(key_valid), 32'h0);
        checkOutput({tag, ".held_edge"},  32'(key_held),  32'h0);
        checkOutput({tag, ".code_edge"},  32'(key_code),  32'h0);
        repeat (cycles - 1) stepCycle();
        checkOutput({tag, ".col"}, 32'(col_out), 32'h0000_000E);
        modelReset();
        key_mask = '0;
        reset = 1'b0;
    endtask

    // First idle scan out of reset, also walking the column strobe.
    task automatic columnScan(input string tag);
        logic [3:0] exp_col;
        key_mask = '0;
        for (int k = 1; k <= SCAN_CYCLES; k++) begin
            stepCycle();
            if (k == 1 || (k % 8) == 0 || (k % 8) == 7) begin
                exp_col = 4'hF;
                exp_col[(k / 8) % 4] = 1'b0;
                checkOutput($sformatf("%s.col%0d", tag, k), 32'(col_out), 32'(exp_col));
            end
        end
        stepCycle();
        modelScan('0);
        checkModel(tag);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] mask;
        logic [15:0] prev_mask;
        int          r;

        $display("[TB] scan=%0d cycles debounce=%0d repeat=%0d", SCAN_CYCLES, DEBOUNCE_SCANS, REPEAT_SCANS);
        modelReset();
        doReset(3, "reset");
        columnScan("idle");

        repeat (3) applyStimulus(maskOf(4'h5), "key5");
        repeat (2) applyStimulus('0, "key5_rel");
        applyStimulus('0, "key5_quiet");

        repeat (3) begin
            applyStimulus(maskOf(4'hD), "keyD_bounce_on");
            applyStimulus('0, "keyD_bounce_off");
        end
        repeat (3) applyStimulus(maskOf(4'hD), "keyD_stable");
        repeat (3) applyStimulus('0, "keyD_rel");

        repeat (2) applyStimulus(maskOf(4'h1) | maskOf(4'h2), "key12_multi");
        repeat (3) applyStimulus(maskOf(4'h1), "key1_only");
        repeat (3) applyStimulus('0, "key1_rel");

        repeat (3) applyStimulus(maskOf(4'h9), "key9");
        applyStimulus('0, "key9_reldb");
        doReset(3, "midreset");
        columnScan("post_reset");
        applyStimulus('0, "post_reset_quiet");

        repeat (14) applyStimulus(maskOf(4'hA), "keyA_hold");
        repeat (3) applyStimulus('0, "keyA_rel");

        prev_mask = '0;
        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(9, 0);
            if (r <= 2) begin
                mask = '0;
            end else if (r <= 6) begin
                mask = prev_mask;
            end else if (r <= 8) begin
                mask = maskOf(4'($urandom_range(15, 0)));
            end else begin
                mask = maskOf(4'($urandom_range(15, 0))) | maskOf(4'($urandom_range(15, 0)));
            end
            applyStimulus(mask, $sformatf("rand%0d", s));
            prev_mask = mask;
        end
        repeat (3) applyStimulus('0, "final_rel");

        checkOutput("code_changes_without_valid", 32'(code_change_bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
